// File: rtl/fifo_pkg.sv
// Shared definitions for the credit-based fifo transmitter: FSM state codes and
// the credit counter width helper.
package fifo_pkg;

   typedef logic [1:0] state_t;

   // FSM states mirror how full the remote fifo is
   localparam state_t HAS_CREDIT  = 2'b00;
   localparam state_t LAST_CREDIT = 2'b01;
   localparam state_t NO_CREDIT   = 2'b10;

   // Width needed to hold every count from 0 up to and including depth
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter, saturating at CREDITS and at zero, reset to CREDITS.
// Also exposes the next count so the owner can derive state from it.
module credit_counter
   import fifo_pkg::*;
#(
   parameter int unsigned    CREDITS   = 8,
   localparam int unsigned   CNT_WIDTH = cnt_width(CREDITS)
) (
   input  logic                 clk,
   input  logic                 nreset_i,
   input  logic                 inc,
   input  logic                 dec,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic [CNT_WIDTH-1:0] count_nxt_c
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(CREDITS);

   // Next count: simultaneous inc and dec cancel; both ends saturate
   always_comb begin
      count_nxt_c = count_o;
      if (inc && !dec) begin
         if (count_o != MAX_CNT) count_nxt_c = count_o + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
         if (count_o != '0) count_nxt_c = count_o - CNT_WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) count_o <= MAX_CNT;
      else           count_o <= count_nxt_c;
   end

endmodule

// File: rtl/fifo_credit_tx.sv
// Credit-based transmitter feeding a remote fifo over a link without backpressure.
// Words are pushed onto a registered link only while credits remain; each credit_i
// pulse returns one credit. Optional error flag is enabled by CREDIT_TX_ERR_EN.
module fifo_credit_tx
   import fifo_pkg::*;
#(
   parameter int unsigned    DATA_WIDTH = 32,
   parameter int unsigned    CREDITS    = 8,
   localparam int unsigned   CNT_WIDTH  = cnt_width(CREDITS)
) (
   input  logic                  clk,
   input  logic                  nreset_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  data_i_valid,
   output logic                  data_i_ready,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  data_o_valid,
   input  logic                  credit_i,
`ifdef CREDIT_TX_ERR_EN
   output logic                  err_o,
`endif
   output logic [CNT_WIDTH-1:0]  credits_o
);

   state_t               state_q;
   state_t               state_nxt;
   logic                 push_c;
   logic [CNT_WIDTH-1:0] count_nxt_c;

   assign push_c = data_i_valid & data_i_ready;

   credit_counter #(
      .CREDITS     (CREDITS)
   ) u_credit_counter (
      .clk         (clk),
      .nreset_i    (nreset_i),
      .inc         (credit_i),
      .dec         (push_c),
      .count_o     (credits_o),
      .count_nxt_c (count_nxt_c)
   );

   // State register
   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) state_q <= HAS_CREDIT;
      else           state_q <= state_nxt;
   end

   // Next state tracks the next credit count so state and credits_o agree
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         HAS_CREDIT:  if (count_nxt_c == CNT_WIDTH'(1)) state_nxt = LAST_CREDIT;
         LAST_CREDIT: begin
            if (push_c && !credit_i)      state_nxt = NO_CREDIT;
            else if (credit_i && !push_c) state_nxt = HAS_CREDIT;
         end
         NO_CREDIT:   if (credit_i) state_nxt = LAST_CREDIT;
         default:     state_nxt = HAS_CREDIT;
      endcase
   end

   // Ready is decoded from registered state only
   always_comb begin
      data_i_ready = (state_q != NO_CREDIT);
   end

   // Link output register; data holds when nothing is pushed
   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         data_o_valid <= 1'b0;
         data_o       <= '0;
      end else begin
         data_o_valid <= push_c;
         if (push_c) data_o <= data_i;
      end
   end

`ifdef CREDIT_TX_ERR_EN
   logic valid_q;
   logic ready_q;
   logic overflow_c;
   logic hold_err_c;

   assign overflow_c = credit_i && !push_c && (credits_o == CNT_WIDTH'(CREDITS));
   assign hold_err_c = valid_q && !data_i_valid && !ready_q;

   // Sticky protocol error: credit overflow or source dropping valid while stalled
   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         err_o   <= 1'b0;
      end else begin
         valid_q <= data_i_valid;
         ready_q <= data_i_ready;
         if (overflow_c || hold_err_c) err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Randomized self-checking bench for fifo_credit_tx with an 8-deep remote fifo model.
module tb_fifo_credit_tx;

   localparam int unsigned DW = 32;
   localparam int unsigned CR = 8;
   localparam int unsigned CW = $clog2(CR + 1);

   logic          clk = 1'b0;
   logic          nreset_i;
   logic [DW-1:0] data_i;
   logic          data_i_valid;
   logic          data_i_ready;
   logic [DW-1:0] data_o;
   logic          data_o_valid;
   logic          credit_i;
   logic [CW-1:0] credits_o;
`ifdef CREDIT_TX_ERR_EN
   logic          err_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: credit count, link register contents, error flag
   int          m_credits;
   logic        m_dvalid;
   logic [31:0] m_data;
   logic        m_err;
   logic        m_prev_v;
   logic        m_prev_rdy;
   logic [31:0] exp_q[$];
   logic [31:0] rem_q[$];

   fifo_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
      .clk          (clk),
      .nreset_i     (nreset_i),
      .data_i       (data_i),
      .data_i_valid (data_i_valid),
      .data_i_ready (data_i_ready),
      .data_o       (data_o),
      .data_o_valid (data_o_valid),
      .credit_i     (credit_i),
`ifdef CREDIT_TX_ERR_EN
      .err_o        (err_o),
`endif
      .credits_o    (credits_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_credits  = CR;
      m_dvalid   = 1'b0;
      m_data     = '0;
      m_err      = 1'b0;
      m_prev_v   = 1'b0;
      m_prev_rdy = 1'b1;
      exp_q.delete();
      rem_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_ready"},   64'(data_i_ready), 64'(m_credits > 0));
      check({tag, "_credits"}, 64'(credits_o), 64'(m_credits));
      check({tag, "_dvalid"},  64'(data_o_valid), 64'(m_dvalid));
      check({tag, "_data"},    64'(data_o), 64'(m_data));
`ifdef CREDIT_TX_ERR_EN
      check({tag, "_err"},     64'(err_o), 64'(m_err));
`endif
   endtask

   // One clock cycle: drive inputs, advance model, sample after the edge
   task automatic cycle(input string tag, input logic v, input logic [31:0] d,
                        input logic c, output logic pushed);
      logic [31:0] got;
      data_i       = d;
      data_i_valid = v;
      credit_i     = c;
      if (c && rem_q.size() > 0) void'(rem_q.pop_front());
      pushed = v && (m_credits > 0);
      if (c && m_credits == CR && !pushed) m_err = 1'b1;
      if (m_prev_v && !v && !m_prev_rdy)   m_err = 1'b1;
      m_prev_v   = v;
      m_prev_rdy = (m_credits > 0);
      if (pushed && !c)                       m_credits--;
      else if (!pushed && c && m_credits < CR) m_credits++;
      m_dvalid = pushed;
      if (pushed) begin
         m_data = d;
         exp_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
      check({tag, "_range"}, 64'(credits_o <= CW'(CR)), 64'd1);
      if (data_o_valid) begin
         if (exp_q.size() == 0) begin
            check({tag, "_spurious"}, 64'(data_o), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            got = exp_q.pop_front();
            check({tag, "_order"}, 64'(data_o), 64'(got));
         end
         rem_q.push_back(data_o);
         check({tag, "_remote_depth"}, 64'(rem_q.size() <= CR), 64'd1);
      end
   endtask

   initial begin
      logic        p;
      logic        p1;
      logic        p2;
      logic        v;
      logic [31:0] word;
      int          pushes;
      int          cyc;

      nreset_i     = 1'b0;
      data_i       = '0;
      data_i_valid = 1'b0;
      credit_i     = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      nreset_i = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("post_reset");

      // 1: fill all eight credits with words 1..8, word 9 held
      word = 32'd1;
      for (int i = 0; i < 9; i++) begin
         cycle("t1", 1'b1, word, 1'b0, p);
         if (p) word++;
      end
      check("t1_pushes", 64'(word), 64'd9);
      check("t1_ready_low", 64'(data_i_ready), 64'd0);

      // 2: one credit from empty releases exactly word 9
      cycle("t2_credit", 1'b1, word, 1'b1, p);
      check("t2_ready_next", 64'(data_i_ready), 64'd1);
      cycle("t2_push", 1'b1, word, 1'b0, p);
      if (p) word++;
      check("t2_word9", 64'(data_o), 64'd9);

      // 3: at one credit, push and credit together keep the count at one
      cycle("t3_credit", 1'b1, word, 1'b1, p);
      cycle("t3_both", 1'b1, word, 1'b1, p);
      if (p) word++;
      check("t3_credits", 64'(credits_o), 64'd1);
      check("t3_dvalid", 64'(data_o_valid), 64'd1);
      cycle("t3_idle", 1'b0, 32'd0, 1'b0, p);

      // Remote drains back to full
      for (int i = 0; i < 7; i++) cycle("refill", 1'b0, 32'd0, 1'b1, p);
      check("refill_full", 64'(credits_o), 64'(CR));

      // 4: remote pops every word two cycles after it is pushed
      pushes = 0;
      p1 = 1'b0;
      p2 = 1'b0;
      cyc = 0;
      while (pushes < 100 && cyc < 2000) begin
         v = ($urandom_range(0, 3) != 0);
         cycle("t4", v, $urandom, p2, p);
         if (p) pushes++;
         p2 = p1;
         p1 = p;
         cyc++;
      end
      check("t4_pushes", 64'(pushes), 64'd100);
      cycle("t4_drain0", 1'b0, 32'd0, p2, p);
      p2 = p1;
      cycle("t4_drain1", 1'b0, 32'd0, p2, p);
      check("t4_full", 64'(credits_o), 64'(CR));
      check("t4_delivered", 64'(exp_q.size()), 64'd0);

      // 5: credit at full count saturates
      cycle("t5_overflow", 1'b0, 32'd0, 1'b1, p);
      check("t5_sat", 64'(credits_o), 64'(CR));
      cycle("t5_hold", 1'b0, 32'd0, 1'b0, p);
`ifdef CREDIT_TX_ERR_EN
      check("t5_err_sticky", 64'(err_o), 64'd1);
`endif

      // 6: reset with a word in flight drops valid immediately
      cycle("t6_push", 1'b1, 32'hA5A5_5A5A, 1'b0, p);
      check("t6_inflight", 64'(data_o_valid), 64'd1);
      nreset_i     = 1'b0;
      data_i_valid = 1'b0;
      credit_i     = 1'b0;
      model_reset();
      #1;
      check("t6_async_dvalid", 64'(data_o_valid), 64'd0);
      check("t6_async_credits", 64'(credits_o), 64'(CR));
      repeat (2) @(posedge clk);
      @(negedge clk);
      nreset_i = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("t6_release");
      cycle("t6_after", 1'b1, 32'h1234_5678, 1'b0, p);
      check("t6_after_credits", 64'(credits_o), 64'(CR - 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
